// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX between NUM_REQ byte producers.
// Latency: request sampled at cycle N gives the TX_IN_V load strobe at N+1; ack when TX_Busy rises.
// Backpressure: requesters hold req_valid until req_ack; no grant while TX_Busy is high.
module uart_tx_arbiter #(
    parameter int WIDTH         = 8,
    parameter int NUM_REQ       = 4,
    parameter int ID_WIDTH      = 2,
    parameter int START_TIMEOUT = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       arb_en,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic [WIDTH-1:0]           TX_IN_P,
    output logic                       TX_IN_V,
    input  logic                       TX_Busy,
    output logic                       grant_active,
    output logic [ID_WIDTH-1:0]        grant_id,
    output logic                       timeout_err,
    output logic [15:0]                sent_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

    state_t              state;
    logic [ID_WIDTH-1:0] ptr;
    logic [7:0]          tmo_cnt;

    logic                win_vld;
    logic [ID_WIDTH-1:0] win_id;
    logic [WIDTH-1:0]    win_dat;

    // Search starts just after the last served index so every valid requester gets a turn.
    always_comb begin
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win_id  = '0;
        win_dat = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + 1 + k) % NUM_REQ;
            if (!win_vld && req_valid[idx]) begin
                win_vld = 1'b1;
                win_id  = ID_WIDTH'(idx);
                win_dat = req_data[idx*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            ptr          <= ID_WIDTH'(NUM_REQ - 1);
            tmo_cnt      <= '0;
            TX_IN_P      <= '0;
            TX_IN_V      <= 1'b0;
            req_ack      <= '0;
            grant_active <= 1'b0;
            grant_id     <= '0;
            timeout_err  <= 1'b0;
            sent_cnt     <= '0;
        end else begin
            TX_IN_V     <= 1'b0;
            req_ack     <= '0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_en && !TX_Busy && win_vld) begin
                        TX_IN_P      <= win_dat;
                        TX_IN_V      <= 1'b1;
                        grant_id     <= win_id;
                        grant_active <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= WAIT_START;
                end
                WAIT_START: begin
                    if (TX_Busy) begin
                        req_ack[grant_id] <= 1'b1;
                        sent_cnt          <= sent_cnt + 16'd1;
                        state             <= WAIT_DONE;
                    end else if (tmo_cnt == 8'(START_TIMEOUT - 1)) begin
                        // Transmitter never started: drop the grant, requester retries in turn.
                        timeout_err  <= 1'b1;
                        ptr          <= grant_id;
                        grant_active <= 1'b0;
                        tmo_cnt      <= '0;
                        state        <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!TX_Busy) begin
                        ptr          <= grant_id;
                        grant_active <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: scoreboarded frames/acks against a simple UART TX busy model.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arb_en;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic [7:0]  tx_in_p;
    logic        tx_in_v;
    logic        tx_busy;
    logic        grant_active;
    logic [1:0]  grant_id;
    logic        timeout_err;
    logic [15:0] sent_cnt;

    int checks   = 0;
    int failures = 0;
    int tmo_seen = 0;

    logic [7:0] exp_frame[$];
    logic [3:0] exp_ack[$];

    // UART TX model: busy rises the cycle after a load and stays high busy_len cycles.
    logic       tx_auto  = 1'b1;
    int         busy_len = 10;
    int         busy_cnt = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter dut (
        .CLK          (clk),
        .RST          (rst_n),
        .arb_en       (arb_en),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ack      (req_ack),
        .TX_IN_P      (tx_in_p),
        .TX_IN_V      (tx_in_v),
        .TX_Busy      (tx_busy),
        .grant_active (grant_active),
        .grant_id     (grant_id),
        .timeout_err  (timeout_err),
        .sent_cnt     (sent_cnt)
    );

    always @(posedge clk) begin
        if (tx_in_v && tx_auto)
            busy_cnt <= busy_len;
        else if (busy_cnt != 0)
            busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard: every load strobe and every ack is matched against what was pushed.
    always @(negedge clk) begin
        if (tx_in_v) begin
            if (exp_frame.size() == 0) chk("frame_extra", 32'(tx_in_v), 32'd0);
            else                       chk("frame", 32'(tx_in_p), 32'(exp_frame.pop_front()));
        end
        if (req_ack != 4'b0) begin
            if (exp_ack.size() == 0) chk("ack_extra", 32'(req_ack), 32'd0);
            else                     chk("ack", 32'(req_ack), 32'(exp_ack.pop_front()));
        end
        if (timeout_err) tmo_seen++;
    end

    task automatic wait_acks(input int n);
        int c = 0;
        int t = 0;
        while (c < n && t < 300) begin
            @(negedge clk);
            t++;
            if (req_ack != 4'b0) c++;
        end
        chk("ack_wait", c, n);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((grant_active || tx_busy) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("idle_wait", 32'(grant_active), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        arb_en    = 1'b1;
        req_valid = 4'b0;
        req_data  = 32'b0;
        repeat (3) @(negedge clk);
        chk("rst_grant_active", 32'(grant_active), 32'd0);
        chk("rst_txv", 32'(tx_in_v), 32'd0);
        chk("rst_txp", 32'(tx_in_p), 32'd0);
        chk("rst_ack", 32'(req_ack), 32'd0);
        chk("rst_sent", 32'(sent_cnt), 32'd0);
        chk("rst_tmo", 32'(timeout_err), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        rst_n = 1'b1;

        // Single request
        @(negedge clk);
        req_data[7:0] = 8'hA5;
        exp_frame.push_back(8'hA5);
        exp_ack.push_back(4'b0001);
        req_valid = 4'b0001;
        @(negedge clk);
        chk("t1_latency_txv", 32'(tx_in_v), 32'd1);
        chk("t1_txp", 32'(tx_in_p), 32'hA5);
        chk("t1_grant_active", 32'(grant_active), 32'd1);
        chk("t1_gid", 32'(grant_id), 32'd0);
        @(negedge clk);
        chk("t1_txv_pulse", 32'(tx_in_v), 32'd0);
        wait_acks(1);
        chk("t1_sent", 32'(sent_cnt), 32'd1);
        req_valid = 4'b0;
        @(negedge clk);
        chk("t1_ack_pulse", 32'(req_ack), 32'd0);
        n = 0;
        while (tx_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t1_ga_at_busy_fall", 32'(grant_active), 32'd1);
        @(negedge clk);
        chk("t1_ga_after_busy_fall", 32'(grant_active), 32'd0);

        // Fairness with all four requesters, fresh pointer
        pulse_reset();
        busy_len = 3;
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'(8'h10 + i);
        for (int i = 0; i < 5; i++) begin
            exp_frame.push_back(8'(8'h10 + (i % 4)));
            exp_ack.push_back(4'(1 << (i % 4)));
        end
        req_valid = 4'b1111;
        wait_acks(5);
        req_valid = 4'b0;
        chk("fair_sent", 32'(sent_cnt), 32'd5);
        wait_idle();

        // Start timeout, then retry of the same requester
        tx_auto = 1'b0;
        req_data[7:0] = 8'h5A;
        exp_frame.push_back(8'h5A);
        req_valid = 4'b0001;
        n = 0;
        while (!tx_in_v && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_grant_seen", 32'(tx_in_v), 32'd1);
        n = 0;
        while (!timeout_err && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_latency", n, 32'd17);
        chk("tmo_sent_unchanged", 32'(sent_cnt), 32'd5);
        chk("tmo_grant_dropped", 32'(grant_active), 32'd0);
        tx_auto = 1'b1;
        exp_frame.push_back(8'h5A);
        exp_ack.push_back(4'b0001);
        @(negedge clk);
        chk("tmo_regrant_txv", 32'(tx_in_v), 32'd1);
        chk("tmo_regrant_gid", 32'(grant_id), 32'd0);
        wait_acks(1);
        req_valid = 4'b0;
        chk("tmo_retry_sent", 32'(sent_cnt), 32'd6);
        wait_idle();

        // arb_en gating
        arb_en = 1'b0;
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'(8'h40 + i);
        req_valid = 4'b1111;
        repeat (20) @(negedge clk);
        chk("gate_no_grant", 32'(grant_active), 32'd0);
        exp_frame.push_back(8'h41);
        exp_ack.push_back(4'b0010);
        arb_en = 1'b1;
        @(negedge clk);
        chk("gate_resume_txv", 32'(tx_in_v), 32'd1);
        chk("gate_resume_gid", 32'(grant_id), 32'd1);
        arb_en = 1'b0;
        wait_acks(1);
        req_valid = 4'b1101;
        wait_idle();
        repeat (10) @(negedge clk);
        chk("gate_no_more_grant", 32'(grant_active), 32'd0);
        chk("gate_last_gid", 32'(grant_id), 32'd1);
        exp_frame.push_back(8'h42);
        exp_ack.push_back(4'b0100);
        arb_en = 1'b1;
        @(negedge clk);
        chk("gate_next_gid", 32'(grant_id), 32'd2);
        wait_acks(1);
        req_valid = 4'b0;
        chk("gate_sent", 32'(sent_cnt), 32'd8);
        wait_idle();

        // Reset while the frame is draining
        busy_len = 10;
        req_data[7:0] = 8'h77;
        exp_frame.push_back(8'h77);
        exp_ack.push_back(4'b0001);
        req_valid = 4'b0001;
        wait_acks(1);
        chk("mid_sent_before", 32'(sent_cnt), 32'd9);
        req_data[7:0]   = 8'h30;
        req_data[23:16] = 8'h32;
        req_valid = 4'b0101;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ga", 32'(grant_active), 32'd0);
        chk("mid_rst_ack", 32'(req_ack), 32'd0);
        chk("mid_rst_sent", 32'(sent_cnt), 32'd0);
        chk("mid_rst_txv", 32'(tx_in_v), 32'd0);
        chk("mid_rst_gid", 32'(grant_id), 32'd0);
        exp_frame.push_back(8'h30);
        exp_frame.push_back(8'h32);
        exp_ack.push_back(4'b0001);
        exp_ack.push_back(4'b0100);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_busy_after_rst", 32'(tx_busy), 32'd1);
        n = 0;
        while (tx_busy && n < 30) begin
            @(negedge clk);
            n++;
            if (tx_busy) chk("mid_no_grant_busy", 32'(grant_active), 32'd0);
        end
        wait_acks(1);
        req_valid = 4'b0100;
        wait_acks(1);
        req_valid = 4'b0;
        chk("mid_sent_after", 32'(sent_cnt), 32'd2);
        wait_idle();

        // Counter wrap from a preloaded value
        @(negedge clk);
        force dut.sent_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.sent_cnt;
        chk("wrap_preload", 32'(sent_cnt), 32'hFFFE);
        busy_len = 2;
        req_data[7:0] = 8'h99;
        exp_frame.push_back(8'h99);
        exp_frame.push_back(8'h99);
        exp_ack.push_back(4'b0001);
        exp_ack.push_back(4'b0001);
        req_valid = 4'b0001;
        wait_acks(1);
        chk("wrap_ffff", 32'(sent_cnt), 32'hFFFF);
        wait_acks(1);
        req_valid = 4'b0;
        chk("wrap_zero", 32'(sent_cnt), 32'h0000);
        wait_idle();

        repeat (5) @(negedge clk);
        chk("frames_left", exp_frame.size(), 32'd0);
        chk("acks_left", exp_ack.size(), 32'd0);
        chk("timeout_pulses", tmo_seen, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares the single UART transmit path between NUM_REQ byte producers.
- Drives the TX parallel load handshake (TX_IN_P / TX_IN_V) and sequences each frame by tracking TX_Busy.
- Grants one requester per frame, acks it when the transmitter starts, and recovers via timeout if the transmitter never starts.
- Sits between on-chip producers and the UART top-level TX inputs.

Parameters:
- WIDTH, 8, data width of one frame payload.
- NUM_REQ, 4, number of requesters (2..8).
- ID_WIDTH, 2, width of grant_id; must be at least clog2(NUM_REQ).
- START_TIMEOUT, 16, cycles to wait for TX_Busy to rise after TX_IN_V (range 2..255).

Ports:
- CLK  input  1  single clock, shared with the UART TX clock domain.
- RST  input  1  asynchronous, active-low reset.
- arb_en  input  1  1 = new grants allowed; 0 = no new grants, frame in flight completes.
- req_valid  input  NUM_REQ  per-requester frame request.
- req_data  input  NUM_REQ*WIDTH  payloads; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ack  output  NUM_REQ  one-cycle pulse when requester i's frame has started.
- TX_IN_P  output  WIDTH  payload to the UART TX.
- TX_IN_V  output  1  one-cycle load strobe to the UART TX.
- TX_Busy  input  1  busy flag from the UART TX.
- grant_active  output  1  high from grant until frame completion.
- grant_id  output  ID_WIDTH  index of the current or most recent grant.
- timeout_err  output  1  one-cycle pulse on start timeout.
- sent_cnt  output  16  count of frames acked; wraps from 0xFFFF to 0.

Behaviour:
- Reset (RST=0, async): state IDLE; all outputs 0; rr pointer = NUM_REQ-1, so requester 0 has first priority; timeout counter 0.
- All outputs are registered.

IDLE:
- Grant condition: arb_en=1, TX_Busy=0 and any req_valid=1.
- Winner is the first valid index searched from ptr+1 upward, wrapping modulo NUM_REQ.
- On the grant edge: latch req_data[winner] into the payload register, set grant_id=winner and grant_active=1, go to ISSUE.
- No grant if TX_Busy=1 (e.g. a frame still draining after reset release).

ISSUE:
- TX_IN_V=1 for exactly one cycle with TX_IN_P = latched payload.
- Latency: request sampled at cycle N gives TX_IN_V at cycle N+1.
- Next state: WAIT_START; clear the timeout counter.

WAIT_START:
- When TX_Busy=1: pulse req_ack[grant_id], increment sent_cnt, go to WAIT_DONE.
- Otherwise increment the counter. When it reaches START_TIMEOUT: pulse timeout_err, no ack, ptr=grant_id, grant_active=0, go to IDLE.
- After a timeout the requester is retried later in round-robin order.

WAIT_DONE:
- When TX_Busy=0: ptr=grant_id, grant_active=0, go to IDLE.
- Earliest next TX_IN_V is 2 cycles after TX_Busy falls (IDLE, then ISSUE).

Requester rules:
- Hold req_valid until req_ack.
- Payload is sampled at grant. Data changes or a req_valid drop after grant do not affect the frame in flight; the frame is still sent and acked.
- A requester wanting back-to-back frames keeps req_valid high after its ack. It re-competes only after every other valid requester has been served once.

Other cases:
- arb_en toggling low mid-frame has no effect on the frame in flight.
- A single active requester is granted every frame.
- Mid-operation reset aborts immediately: TX_IN_V=0 and no ack is issued; the frame already loaded in the UART TX is not tracked.

Test Plan:
- Single request: req_valid=0001, data[0]=0xA5, TX model raises Busy 1 cycle after TX_IN_V and holds it 10 cycles -> TX_IN_V one cycle with TX_IN_P=0xA5; req_ack=0001 one cycle; sent_cnt=1; grant_active falls 1 cycle after Busy falls.
- Fairness: all four valid continuously, data i = 0x10+i -> frame order 0x10, 0x11, 0x12, 0x13, 0x10; exactly one ack per frame.
- Timeout: TX model never raises Busy, START_TIMEOUT=16 -> timeout_err pulse 16 cycles after WAIT_START entry; no req_ack; sent_cnt unchanged; req 0 regranted.
- Gating: arb_en=0 with req_valid=1111 -> no TX_IN_V; drop arb_en mid-frame -> frame completes, no further grant; reassert -> grant resumes at ptr+1.
- Reset mid-frame: assert RST low in WAIT_DONE -> outputs 0 asynchronously; after release, req 0 wins first; no grant while Busy=1.
- Counter wrap: preload via 65536 frames (or force) -> sent_cnt goes 0xFFFF -> 0x0000.
